mimo_sym_packer: RTL and testbench

//  Downstream of the 4x4 QPSK demapper. Each cycle accepts one detected vector (four 2-bit

---
 rtl/mimo_sym_packer.sv | 122 ++++++++++++
 tb/tb_mimo_sym_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mimo_sym_packer.sv
// Packs detected 4x4 QPSK vectors (one byte each) into 32-bit words with frame marking and an
// output FIFO. Define SYM_PACK_GRAY_EN to Gray-map each 2-bit symbol index before packing.
module mimo_sym_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAME_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    demod_1,
  input  logic [2:0]                    demod_2,
  input  logic [2:0]                    demod_3,
  input  logic [2:0]                    demod_4,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic                          out_last,
  output logic [2:0]                    out_bytes,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned VecW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  function automatic logic [1:0] map_sym(input logic [1:0] idx);
`ifdef SYM_PACK_GRAY_EN
    return {idx[1], idx[1] ^ idx[0]};
`else
    return idx;
`endif
  endfunction

  logic [7:0]      vec_byte;
  logic            unused_msb;
  logic            accept, pop, push, word_done, frame_end;
  logic [31:0]     push_data;
  logic [2:0]      push_bytes;

  logic [23:0]     pack_reg_q, pack_reg_d;
  logic [1:0]      pack_cnt_q, pack_cnt_d;
  logic [VecW-1:0] vec_cnt_q, vec_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0]     mem_data_q  [FIFO_DEPTH];
  logic [2:0]      mem_bytes_q [FIFO_DEPTH];
  logic            mem_last_q  [FIFO_DEPTH];

  assign vec_byte   = {map_sym(demod_4[1:0]), map_sym(demod_3[1:0]),
                       map_sym(demod_2[1:0]), map_sym(demod_1[1:0])};
  assign unused_msb = ^{demod_1[2], demod_2[2], demod_3[2], demod_4[2]};

  always_comb begin
    accept     = in_valid & in_ready;
    pop        = out_valid & out_ready;
    frame_end  = (vec_cnt_q == VecW'(FRAME_LEN - 1));
    word_done  = (pack_cnt_q == 2'd3) | frame_end;
    push       = accept & word_done;
    // Upper bytes beyond the new one stay zero because pack_reg clears after every push.
    push_data  = {8'h00, pack_reg_q};
    push_data[8*pack_cnt_q +: 8] = vec_byte;
    push_bytes = {1'b0, pack_cnt_q} + 3'd1;
  end

  always_comb begin
    pack_reg_d = pack_reg_q;
    pack_cnt_d = pack_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    if (accept) begin
      vec_cnt_d = frame_end ? '0 : vec_cnt_q + VecW'(1);
      if (word_done) begin
        pack_reg_d = '0;
        pack_cnt_d = '0;
      end else begin
        pack_reg_d = push_data[23:0];
        pack_cnt_d = pack_cnt_q + 2'd1;
      end
    end
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_reg_q <= '0;
      pack_cnt_q <= '0;
      vec_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pack_reg_q <= pack_reg_d;
      pack_cnt_q <= pack_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q]  <= push_data;
      mem_bytes_q[wr_ptr_q] <= push_bytes;
      mem_last_q[wr_ptr_q]  <= frame_end;
    end
  end

  always_comb begin
    in_ready   = (count_q != CntW'(FIFO_DEPTH));
    out_valid  = (count_q != '0);
    out_data   = out_valid ? mem_data_q[rd_ptr_q]  : '0;
    out_bytes  = out_valid ? mem_bytes_q[rd_ptr_q] : '0;
    out_last   = out_valid ? mem_last_q[rd_ptr_q]  : 1'b0;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_mimo_sym_packer.sv
// Directed bench for mimo_sym_packer: packing, frame end, FIFO stall/drain, push+pop, reset.
module tb_mimo_sym_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel6 = 1'b0;
  logic [2:0]  demod_1 = '0, demod_2 = '0, demod_3 = '0, demod_4 = '0;

  logic        in_ready, out_valid, out_last;
  logic [31:0] out_data;
  logic [2:0]  out_bytes, fifo_count;

  logic        in6_valid, in_ready6, out_valid6, out_last6;
  logic [31:0] out_data6;
  logic [2:0]  out_bytes6, fifo_count6;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] rx[$];
  logic [35:0] rx6[$];
  logic [7:0]  exp_b[32];

  assign in6_valid = in_valid & sel6;

  mimo_sym_packer #(.FIFO_DEPTH(4), .FRAME_LEN(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .demod_1(demod_1), .demod_2(demod_2), .demod_3(demod_3), .demod_4(demod_4),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_bytes(out_bytes), .fifo_count(fifo_count)
  );

  mimo_sym_packer #(.FIFO_DEPTH(4), .FRAME_LEN(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in6_valid), .in_ready(in_ready6),
    .demod_1(demod_1), .demod_2(demod_2), .demod_3(demod_3), .demod_4(demod_4),
    .out_valid(out_valid6), .out_ready(1'b1), .out_data(out_data6),
    .out_last(out_last6), .out_bytes(out_bytes6), .fifo_count(fifo_count6)
  );

  always #5 clk = ~clk;

  // Handshake inputs only change just after posedge, so the negedge sees the popping word.
  always @(negedge clk) begin
    if (out_valid && out_ready) rx.push_back({out_last, out_bytes, out_data});
    if (out_valid6) rx6.push_back({out_last6, out_bytes6, out_data6});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] gmap(input logic [1:0] i);
`ifdef SYM_PACK_GRAY_EN
    return {i[1], i[1] ^ i[0]};
`else
    return i;
`endif
  endfunction

  task automatic gen_vec(input int k, output logic [2:0] a, output logic [2:0] b,
                         output logic [2:0] c, output logic [2:0] d);
    a = {1'b1, k[1:0]};
    b = {1'b0, k[3:2]};
    c = {1'b1, ~k[1:0]};
    d = {1'b0, k[4:3]};
    exp_b[k] = {gmap(d[1:0]), gmap(c[1:0]), gmap(b[1:0]), gmap(a[1:0])};
  endtask

  function automatic logic [31:0] word_at(input int base);
    return {exp_b[base+3], exp_b[base+2], exp_b[base+1], exp_b[base]};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      input logic [2:0] d);
    int i = 0;
    in_valid = 1'b1;
    demod_1 = a; demod_2 = b; demod_3 = c; demod_4 = d;
    while (!in_ready && i < 64) begin
      @(posedge clk); #1;
      i++;
    end
    if (!in_ready) check_eq("send_timeout", in_ready, 1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_k(input int k);
    logic [2:0] a, b, c, d;
    gen_vec(k, a, b, c, d);
    send(a, b, c, d);
  endtask

  task automatic wait_rx(input string tag, input int n);
    int i = 0;
    while (rx.size() < n && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    check_eq(tag, rx.size(), n);
  endtask

  task automatic expect_rx(input string tag, input logic [35:0] exp);
    logic [35:0] got;
    got = (rx.size() > 0) ? rx.pop_front() : 'x;
    check_eq(tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rx.delete();
    rx6.delete();
  endtask

  logic [31:0] w1, w2a, w2b, w6;
  logic [35:0] got6;

  initial begin
`ifdef SYM_PACK_GRAY_EN
    w1 = 32'h2D2D2D2D; w2a = 32'hAAAAAAAA; w2b = 32'h0000AAAA; w6 = 32'hBBBBBBBB;
`else
    w1 = 32'h39393939; w2a = 32'hFFFFFFFF; w2b = 32'h0000FFFF; w6 = 32'hEEEEEEEE;
`endif
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_bytes", out_bytes, 0);
    check_eq("rst_fifo_count", fifo_count, 0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", in_ready, 1);

    // 1: four identical vectors make one full word, visible right after the 4th accept.
    out_ready = 1'b1;
    repeat (3) send(3'd1, 3'd2, 3'd3, 3'd0);
    check_eq("t1_valid_before", out_valid, 0);
    send(3'd1, 3'd2, 3'd3, 3'd0);
    check_eq("t1_valid_after", out_valid, 1);
    check_eq("t1_data", out_data, w1);
    check_eq("t1_bytes", out_bytes, 4);
    check_eq("t1_last", out_last, 0);
    wait_rx("t1_rx_count", 1);
    expect_rx("t1_rx_word", {1'b0, 3'd4, w1});

    // 2: FRAME_LEN=6 instance: full word then 2-byte last word; bit 2 is ignored.
    do_reset();
    sel6 = 1'b1;
    repeat (6) send(3'd7, 3'd7, 3'd7, 3'd7);
    sel6 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t2_rx6_count", rx6.size(), 2);
    got6 = (rx6.size() > 0) ? rx6.pop_front() : 'x;
    check_eq("t2_word0", got6, {1'b0, 3'd4, w2a});
    got6 = (rx6.size() > 0) ? rx6.pop_front() : 'x;
    check_eq("t2_word1", got6, {1'b1, 3'd2, w2b});
    check_eq("t2_vec_cnt", u_dut6.vec_cnt_q, 0);
    wait_rx("t2_rx_count", 1);
    expect_rx("t2_main_word", {1'b0, 3'd4, w2a});

    // 3: stall the sink, fill the FIFO, hold vector 17, then drain.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_k(k);
    check_eq("t3_count_full", fifo_count, 4);
    check_eq("t3_ready_full", in_ready, 0);
    begin
      logic [2:0] a, b, c, d;
      gen_vec(16, a, b, c, d);
      in_valid = 1'b1;
      demod_1 = a; demod_2 = b; demod_3 = c; demod_4 = d;
    end
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t3_count_held", fifo_count, 4);
    check_eq("t3_head_stable", out_data, word_at(0));
    check_eq("t3_ready_held", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t3_ready_after_pop", in_ready, 1);
    check_eq("t3_count_after_pop", fifo_count, 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 17; k < 20; k++) send_k(k);
    wait_rx("t3_rx_count", 5);
    for (int j = 0; j < 5; j++)
      expect_rx($sformatf("t3_word%0d", j), {(j == 3), 3'd4, word_at(4*j)});

    // 4: push and pop on the same edge with two words buffered.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 11; k++) send_k(k);
    check_eq("t4_count_pre", fifo_count, 2);
    out_ready = 1'b1;
    send_k(11);
    out_ready = 1'b0;
    check_eq("t4_count_pushpop", fifo_count, 2);
    out_ready = 1'b1;
    wait_rx("t4_rx_count", 3);
    for (int j = 0; j < 3; j++)
      expect_rx($sformatf("t4_word%0d", j), {1'b0, 3'd4, word_at(4*j)});

    // 5: asynchronous reset with a buffered word and a partial word in flight.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send_k(k);
    check_eq("t5_valid_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", out_valid, 0);
    check_eq("t5_rst_data", out_data, 0);
    check_eq("t5_rst_last", out_last, 0);
    check_eq("t5_rst_bytes", out_bytes, 0);
    check_eq("t5_rst_count", fifo_count, 0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    rx.delete();
    check_eq("t5_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 8; k < 12; k++) send_k(k);
    wait_rx("t5_rx_count", 1);
    expect_rx("t5_word", {1'b0, 3'd4, word_at(8)});

    // 6: symbol mapping for (2,3,2,3).
    do_reset();
    out_ready = 1'b1;
    repeat (4) send(3'd2, 3'd3, 3'd2, 3'd3);
    wait_rx("t6_rx_count", 1);
    expect_rx("t6_word", {1'b0, 3'd4, w6});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
